// File: rtl/grf_wb_arbiter_pkg.sv
// Shared definitions for the GRF write-port arbiter.
// Provides register-file geometry, the buffered MDU result entry and a
// helper that turns a register address into its one-hot bit in a
// per-register mask.
package grf_wb_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int PC_W       = 32;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
    logic [PC_W-1:0]       pc;
  } wb_entry_t;

  function automatic logic [NUM_REGS-1:0] addr_onehot(input logic [REG_ADDR_W-1:0] addr);
    addr_onehot       = '0;
    addr_onehot[addr] = 1'b1;
  endfunction

endpackage

// File: rtl/grf_wb_arbiter_wb_fifo.sv
// In-order buffer for MDU results waiting for the GRF write port.
// Ports:
//   clk, reset      clock, asynchronous active-high reset (clears control)
//   push/push_entry enqueue an entry (ignored while full)
//   pop             dequeue the head (ignored while empty)
//   full, empty     occupancy flags
//   head            oldest entry; only meaningful while !empty
//   entry_valid     per-slot occupancy
//   entry_addr      per-slot destination register, slot i at [i*REG_ADDR_W +: REG_ADDR_W]
module wb_fifo
  import grf_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  wb_entry_t                   push_entry,
  input  logic                        pop,
  output logic                        full,
  output logic                        empty,
  output wb_entry_t                   head,
  output logic [DEPTH-1:0]            entry_valid,
  output logic [DEPTH*REG_ADDR_W-1:0] entry_addr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [DEPTH-1:0] valid;
  logic             do_push;
  logic             do_pop;

  assign full        = (count == DEPTH_C);
  assign empty       = (count == '0);
  assign do_push     = push && !full;
  assign do_pop      = pop && !empty;
  assign head        = mem[rd_ptr];
  assign entry_valid = valid;

  // Payload storage carries no reset; slot occupancy is tracked by valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      valid  <= '0;
    end else begin
      if (do_pop) begin
        valid[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + 1'b1;
      end
      if (do_push) begin
        valid[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_addr_view
    assign entry_addr[i*REG_ADDR_W +: REG_ADDR_W] = mem[i].addr;
  end

endmodule

// File: rtl/grf_wb_arbiter.sv
// Arbitrates the single GRF write port between the pipeline writeback stage
// (priority) and the MDU result path (buffered in an in-order FIFO). A
// starvation counter inserts a one-cycle pipeline stall so buffered results
// drain, and a pending-write mask tells the hazard unit which registers have
// results still in flight.
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   wb_en/wb_addr/wb_data/wb_pc    pipeline writeback request
//   md_valid/md_addr/md_data/md_pc MDU result, accepted when md_ready
//   md_ready                       buffer can take an MDU result this cycle
//   pipe_stall                     registered; WB request held and not granted
//   grf_we/grf_addr/grf_data/grf_pc GRF write port
//   pending_mask                   bit r set while a buffered result targets r
module grf_wb_arbiter
  import grf_wb_arbiter_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic [PC_W-1:0]       wb_pc,
  input  logic                  md_valid,
  input  logic [REG_ADDR_W-1:0] md_addr,
  input  logic [DATA_W-1:0]     md_data,
  input  logic [PC_W-1:0]       md_pc,
  output logic                  md_ready,
  output logic                  pipe_stall,
  output logic                  grf_we,
  output logic [REG_ADDR_W-1:0] grf_addr,
  output logic [DATA_W-1:0]     grf_data,
  output logic [PC_W-1:0]       grf_pc,
  output logic [NUM_REGS-1:0]   pending_mask
);

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] LIMIT_C    = STARVE_W'(STARVE_LIMIT);
  localparam logic [STARVE_W-1:0] LIMIT_M1_C = STARVE_W'(STARVE_LIMIT - 1);

  wb_entry_t                   md_entry;
  wb_entry_t                   head;
  logic                        push;
  logic                        full;
  logic                        empty;
  logic [DEPTH-1:0]            entry_valid;
  logic [DEPTH*REG_ADDR_W-1:0] entry_addr;
  logic                        pipe_grant;
  logic                        head_grant;
  logic [STARVE_W-1:0]         starve_cnt;

  // md_ready looks only at pre-edge occupancy: a full buffer refuses a new
  // result even in a cycle where it also pops.
  assign md_ready = !full;
  // $0 results complete the handshake but are never buffered.
  assign push     = md_valid && md_ready && (md_addr != '0);
  assign md_entry = '{addr: md_addr, data: md_data, pc: md_pc};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (md_entry),
    .pop        (head_grant),
    .full       (full),
    .empty      (empty),
    .head       (head),
    .entry_valid(entry_valid),
    .entry_addr (entry_addr)
  );

  // A pipeline write to $0 is dropped, which leaves the port free for the
  // head. Grants are suppressed while reset is held so nothing reaches the GRF.
  assign pipe_grant = !reset && !pipe_stall && wb_en && (wb_addr != '0);
  assign head_grant = !reset && !pipe_grant && !empty;

  always_comb begin
    grf_we   = pipe_grant || head_grant;
    grf_addr = '0;
    grf_data = '0;
    grf_pc   = '0;
    if (pipe_grant) begin
      grf_addr = wb_addr;
      grf_data = wb_data;
      grf_pc   = wb_pc;
    end else if (head_grant) begin
      grf_addr = head.addr;
      grf_data = head.data;
      grf_pc   = head.pc;
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i]) pending_mask |= addr_onehot(entry_addr[i*REG_ADDR_W +: REG_ADDR_W]);
    end
  end

  // Count cycles the head is passed over. Reaching the limit schedules a
  // single stall cycle; that cycle always grants the head, which clears the
  // count again.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
      pipe_stall <= 1'b0;
    end else begin
      pipe_stall <= 1'b0;
      if (empty || head_grant) begin
        starve_cnt <= '0;
      end else if (starve_cnt != LIMIT_C) begin
        starve_cnt <= starve_cnt + 1'b1;
        if (starve_cnt == LIMIT_M1_C) pipe_stall <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Testbench for grf_wb_arbiter: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_grf_wb_arbiter;

  localparam int DEPTH        = 2;
  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] wb_pc;
  logic        md_valid;
  logic [4:0]  md_addr;
  logic [31:0] md_data;
  logic [31:0] md_pc;
  logic        md_ready;
  logic        pipe_stall;
  logic        grf_we;
  logic [4:0]  grf_addr;
  logic [31:0] grf_data;
  logic [31:0] grf_pc;
  logic [31:0] pending_mask;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    logic [31:0] p;
  } ent_t;

  // Reference model state: buffered results, starvation count, stall flag.
  ent_t q[$];
  int   starve;
  bit   stall_m;

  grf_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk         (clk),
    .reset       (reset),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .wb_pc       (wb_pc),
    .md_valid    (md_valid),
    .md_addr     (md_addr),
    .md_data     (md_data),
    .md_pc       (md_pc),
    .md_ready    (md_ready),
    .pipe_stall  (pipe_stall),
    .grf_we      (grf_we),
    .grf_addr    (grf_addr),
    .grf_data    (grf_data),
    .grf_pc      (grf_pc),
    .pending_mask(pending_mask)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    wb_en = 1'b0; wb_addr = '0; wb_data = '0; wb_pc = '0;
    md_valid = 1'b0; md_addr = '0; md_data = '0; md_pc = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    q.delete();
    starve  = 0;
    stall_m = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL reset_md_ready: got %b want 1", md_ready); end
    checks++; if (grf_we !== 1'b0) begin errors++; $display("FAIL reset_grf_we: got %b want 0", grf_we); end
    checks++; if (pipe_stall !== 1'b0) begin errors++; $display("FAIL reset_pipe_stall: got %b want 0", pipe_stall); end
    checks++; if (pending_mask !== 32'h0) begin errors++; $display("FAIL reset_mask: got %h want 0", pending_mask); end
    checks++; if ({grf_addr, grf_data, grf_pc} !== 69'h0) begin errors++; $display("FAIL reset_grf_fields: got %h/%h/%h want 0", grf_addr, grf_data, grf_pc); end
    @(posedge clk); #1;
  endtask

  task automatic test_pipeline_only();
    do_reset();
    wb_en = 1'b1; wb_addr = 5'd8; wb_data = 32'h1234; wb_pc = 32'h3000;
    @(negedge clk);
    checks++; if (grf_we !== 1'b1) begin errors++; $display("FAIL pipe_we: got %b want 1", grf_we); end
    checks++; if (grf_addr !== 5'd8) begin errors++; $display("FAIL pipe_addr: got %0d want 8", grf_addr); end
    checks++; if (grf_data !== 32'h1234) begin errors++; $display("FAIL pipe_data: got %h want 1234", grf_data); end
    checks++; if (grf_pc !== 32'h3000) begin errors++; $display("FAIL pipe_pc: got %h want 3000", grf_pc); end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic test_mdu_idle();
    do_reset();
    md_valid = 1'b1; md_addr = 5'd9; md_data = 32'hABCD; md_pc = 32'h3010;
    @(negedge clk);
    checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL mdu_ready: got %b want 1", md_ready); end
    checks++; if (grf_we !== 1'b0) begin errors++; $display("FAIL mdu_we_same_cycle: got %b want 0", grf_we); end
    @(posedge clk); #1;
    md_valid = 1'b0;
    checks++; if (pending_mask !== 32'h200) begin errors++; $display("FAIL mdu_mask_set: got %h want 200", pending_mask); end
    @(negedge clk);
    checks++; if (grf_we !== 1'b1 || grf_addr !== 5'd9) begin errors++; $display("FAIL mdu_write: got we=%b addr=%0d want we=1 addr=9", grf_we, grf_addr); end
    checks++; if (grf_data !== 32'hABCD || grf_pc !== 32'h3010) begin errors++; $display("FAIL mdu_payload: got %h/%h want abcd/3010", grf_data, grf_pc); end
    @(posedge clk); #1;
    checks++; if (pending_mask !== 32'h0) begin errors++; $display("FAIL mdu_mask_clear: got %h want 0", pending_mask); end
    checks++; if (grf_we !== 1'b0) begin errors++; $display("FAIL mdu_no_second_write: got %b want 0", grf_we); end
  endtask

  task automatic test_backpressure();
    logic [4:0] send[$];
    logic [4:0] wr[$];
    logic [4:0] want[3];
    int         pushes;
    bit         ready_checked;
    bit         accepted;
    do_reset();
    send = '{5'd3, 5'd4, 5'd6};
    want = '{5'd3, 5'd4, 5'd6};
    pushes = 0;
    ready_checked = 1'b0;
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h55; wb_pc = 32'h5000;
    for (int cyc = 0; cyc < 40 && wr.size() < 3; cyc++) begin
      if (send.size() > 0) begin
        md_valid = 1'b1; md_addr = send[0]; md_data = 32'h100 + 32'(send[0]); md_pc = 32'h4000 + 32'(send[0]);
      end else begin
        md_valid = 1'b0;
      end
      @(negedge clk);
      if (pushes == 2 && !ready_checked) begin
        ready_checked = 1'b1;
        checks++; if (md_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready: got %b want 0", md_ready); end
      end
      if (grf_we === 1'b1 && grf_addr !== 5'd5) begin
        wr.push_back(grf_addr);
        checks++; if (grf_data !== 32'h100 + 32'(grf_addr)) begin errors++; $display("FAIL bp_data: reg %0d got %h want %h", grf_addr, grf_data, 32'h100 + 32'(grf_addr)); end
      end
      accepted = md_valid && md_ready;
      @(posedge clk); #1;
      if (accepted) begin
        void'(send.pop_front());
        pushes++;
      end
    end
    checks++; if (!ready_checked) begin errors++; $display("FAIL bp_pushes: got %0d pushes want at least 2", pushes); end
    checks++;
    if (wr.size() != 3) begin
      errors++; $display("FAIL bp_write_count: got %0d MDU writes want 3", wr.size());
    end else if (wr[0] !== want[0] || wr[1] !== want[1] || wr[2] !== want[2]) begin
      errors++; $display("FAIL bp_order: got %0d,%0d,%0d want 3,4,6", wr[0], wr[1], wr[2]);
    end
    idle_inputs();
  endtask

  task automatic test_starvation();
    logic [4:0] exp_addr;
    do_reset();
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h55; wb_pc = 32'h5000;
    md_valid = 1'b1; md_addr = 5'd10; md_data = 32'hA0A0; md_pc = 32'h4010;
    @(negedge clk);
    checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL starve_ready: got %b want 1", md_ready); end
    @(posedge clk); #1;
    md_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      exp_addr = (c == 5) ? 5'd10 : 5'd5;
      checks++; if (pipe_stall !== (c == 5)) begin errors++; $display("FAIL starve_stall_c%0d: got %b want %b", c, pipe_stall, (c == 5)); end
      checks++; if (grf_we !== 1'b1 || grf_addr !== exp_addr) begin errors++; $display("FAIL starve_grant_c%0d: got we=%b addr=%0d want we=1 addr=%0d", c, grf_we, grf_addr, exp_addr); end
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  task automatic test_zero_reg();
    do_reset();
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h55; wb_pc = 32'h5000;
    md_valid = 1'b1; md_addr = 5'd7; md_data = 32'h77; md_pc = 32'h4070;
    @(negedge clk);
    @(posedge clk); #1;
    checks++; if (pending_mask !== 32'h80) begin errors++; $display("FAIL zero_mask_queued: got %h want 80", pending_mask); end
    md_addr = 5'd0; md_data = 32'hDEAD;
    @(negedge clk);
    checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL zero_md_ready: got %b want 1", md_ready); end
    @(posedge clk); #1;
    md_valid = 1'b0;
    checks++; if (pending_mask !== 32'h80) begin errors++; $display("FAIL zero_mask_unchanged: got %h want 80", pending_mask); end
    wb_addr = 5'd0;
    @(negedge clk);
    checks++; if (grf_we !== 1'b1 || grf_addr !== 5'd7 || grf_data !== 32'h77) begin errors++; $display("FAIL zero_head_grant: got we=%b addr=%0d data=%h want 1/7/77", grf_we, grf_addr, grf_data); end
    @(posedge clk); #1;
    checks++; if (pending_mask !== 32'h0) begin errors++; $display("FAIL zero_mask_popped: got %h want 0", pending_mask); end
    @(negedge clk);
    checks++; if (grf_we !== 1'b0) begin errors++; $display("FAIL zero_not_enqueued: got we=%b addr=%0d want we=0", grf_we, grf_addr); end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic test_reset_midqueue();
    do_reset();
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h55; wb_pc = 32'h5000;
    md_valid = 1'b1; md_addr = 5'd3; md_data = 32'h33; md_pc = 32'h4030;
    @(posedge clk); #1;
    md_addr = 5'd4; md_data = 32'h44; md_pc = 32'h4040;
    @(posedge clk); #1;
    md_valid = 1'b0;
    checks++; if (pending_mask !== 32'h18) begin errors++; $display("FAIL rstq_mask_before: got %h want 18", pending_mask); end
    #2;
    wb_en = 1'b0;
    reset = 1'b1;
    #1;
    checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL rstq_md_ready: got %b want 1", md_ready); end
    checks++; if (pending_mask !== 32'h0) begin errors++; $display("FAIL rstq_mask: got %h want 0", pending_mask); end
    checks++; if (grf_we !== 1'b0) begin errors++; $display("FAIL rstq_grf_we: got %b want 0", grf_we); end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (grf_we !== 1'b0 || pending_mask !== 32'h0) begin errors++; $display("FAIL rstq_after_c%0d: got we=%b mask=%h want 0/0", c, grf_we, pending_mask); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    bit          pg, hg, exp_we, exp_ready, acc, was_empty, nstall;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data, exp_pc, exp_mask;
    ent_t        e;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      // The WB stage holds its request while stalled.
      if (!stall_m) begin
        wb_en   = ($urandom_range(0, 3) != 0);
        wb_addr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        wb_data = $urandom;
        wb_pc   = $urandom;
      end
      md_valid = ($urandom_range(0, 1) == 1);
      md_addr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      md_data  = $urandom;
      md_pc    = $urandom;

      pg        = !stall_m && wb_en && (wb_addr != 5'd0);
      hg        = !pg && (q.size() > 0);
      exp_we    = pg || hg;
      exp_addr  = 5'd0; exp_data = 32'h0; exp_pc = 32'h0;
      if (pg) begin
        exp_addr = wb_addr; exp_data = wb_data; exp_pc = wb_pc;
      end else if (hg) begin
        exp_addr = q[0].a; exp_data = q[0].d; exp_pc = q[0].p;
      end
      exp_ready = (q.size() < DEPTH);
      exp_mask  = 32'h0;
      foreach (q[i]) exp_mask[q[i].a] = 1'b1;

      @(negedge clk);
      checks++; if (grf_we !== exp_we) begin errors++; $display("FAIL rnd_we cyc%0d: got %b want %b", cyc, grf_we, exp_we); end
      checks++; if ({grf_addr, grf_data, grf_pc} !== {exp_addr, exp_data, exp_pc}) begin errors++; $display("FAIL rnd_fields cyc%0d: got %0d/%h/%h want %0d/%h/%h", cyc, grf_addr, grf_data, grf_pc, exp_addr, exp_data, exp_pc); end
      checks++; if (md_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready cyc%0d: got %b want %b", cyc, md_ready, exp_ready); end
      checks++; if (pending_mask !== exp_mask) begin errors++; $display("FAIL rnd_mask cyc%0d: got %h want %h", cyc, pending_mask, exp_mask); end
      checks++; if (pipe_stall !== stall_m) begin errors++; $display("FAIL rnd_stall cyc%0d: got %b want %b", cyc, pipe_stall, stall_m); end

      acc       = md_valid && exp_ready && (md_addr != 5'd0);
      was_empty = (q.size() == 0);
      nstall    = 1'b0;
      if (was_empty || hg) begin
        starve = 0;
      end else if (starve < STARVE_LIMIT) begin
        starve++;
        if (starve == STARVE_LIMIT) nstall = 1'b1;
      end
      stall_m = nstall;
      if (hg) void'(q.pop_front());
      if (acc) begin
        e.a = md_addr; e.d = md_data; e.p = md_pc;
        q.push_back(e);
      end
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_pipeline_only();
    test_mdu_idle();
    test_backpressure();
    test_starvation();
    test_zero_reg();
    test_reset_midqueue();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/grf_wb_arbiter.md
Name: grf_wb_arbiter

Overview:
- Shares the single GRF write port between two writers: the pipeline writeback stage and the long-latency multiply/divide unit (MDU) result path.
- The pipeline has priority. MDU results are buffered in a small in-order FIFO.
- A starvation counter forces a one-cycle pipeline stall so that buffered results drain.
- Sits between the WB stage, the MDU and the GRF. It drives the GRF's write-enable, address, data and pc (display) inputs, and exports a pending-write mask to the hazard unit.

Parameters:
- DEPTH, 2, MDU result FIFO entries (power of two, >=2).
- STARVE_LIMIT, 4, consecutive cycles a non-empty FIFO head may go ungranted before a forced stall.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- wb_en  in  1  pipeline writeback request.
- wb_addr  in  5  pipeline destination register.
- wb_data  in  32  pipeline write data.
- wb_pc  in  32  pc of the writing instruction.
- md_valid  in  1  MDU result valid.
- md_addr  in  5  MDU destination register.
- md_data  in  32  MDU result.
- md_pc  in  32  pc of the MDU instruction.
- md_ready  out  1  FIFO can accept an MDU result this cycle.
- pipe_stall  out  1  registered; WB stage must hold wb_* stable, and this request is not granted.
- grf_we  out  1  GRF write enable.
- grf_addr  out  5  GRF write address.
- grf_data  out  32  GRF write data.
- grf_pc  out  32  pc forwarded to the GRF write display.
- pending_mask  out  32  bit r set iff some FIFO entry targets register r.

Behaviour:
- Reset (async): FIFO empty, count=0, starve_cnt=0, pipe_stall=0. Resulting outputs: md_ready=1, grf_we=0, grf_addr/grf_data/grf_pc=0, pending_mask=0. Reset mid-operation discards queued results with no GRF write.
- Grant (combinational from inputs and registered state):
  - If pipe_stall=0 and wb_en=1 and wb_addr!=0: grant pipeline; grf_* = wb_*.
  - Else if FIFO non-empty: grant head; grf_* = head fields; pop at the clock edge.
  - Else grf_we=0, with addr/data/pc driven to 0.
- $0: pipeline writes to $0 are dropped; that frees the port, so a non-empty FIFO head is granted that cycle. MDU results with md_addr=0 are accepted (handshake completes) but never enqueued.
- Latency: the GRF is written at the same edge as the grant. An MDU result reaches the GRF at the earliest 1 cycle after acceptance.
- Enqueue: at an edge when md_valid && md_ready && md_addr!=0. md_ready = (count<DEPTH), using pre-edge count. A full FIFO is not ready even if it pops the same cycle.
- Simultaneous push+pop: count unchanged, order preserved.
- Starvation:
  - starve_cnt increments each cycle the FIFO is non-empty and its head is not granted, saturating at STARVE_LIMIT.
  - It clears on any pop or when the FIFO is empty.
  - When starve_cnt==STARVE_LIMIT-1 and increments, pipe_stall=1 in the next cycle, for exactly one cycle. That cycle grants the head; pipe_stall then returns to 0.
- pending_mask: OR of the one-hot addresses of valid entries. It updates at the edge, and bits of a popped entry clear the same edge.
- WAW ordering is not resolved here; the hazard unit stalls on pending_mask.

Decomposition:
- Shared package: REG_ADDR_W=5, DATA_W=32, PC_W=32, and an entry struct {addr, data, pc}.
- One natural sub-module: wb_fifo (parameterised DEPTH; push/pop/full/empty/head/count, plus a per-entry address view for pending_mask).

Test Plan:
1. Reset asserted mid-queue: FIFO holds 2 entries; assert reset asynchronously → same instant md_ready=1, pending_mask=0, grf_we=0, with no write after release.
2. Pipeline-only: wb_en=1, addr=8, data=0x1234, pc=0x3000 → grf_we=1, grf_addr=8, grf_data=0x1234, grf_pc=0x3000 that cycle.
3. MDU while pipeline idle: md_valid addr=9 data=0xABCD pc=0x3010 at cycle N → pending_mask=0x200 after edge N; grf_we=1, addr=9 at N+1; mask=0 after edge N+1.
4. Full/backpressure: wb_en held with addr 5; push MDU results for 3 and 4 → md_ready=0 after 2 pushes. Third result (addr 6) held until a slot frees. Write order is 3, 4, 6.
5. Starvation with STARVE_LIMIT=4: FIFO non-empty and wb_en continuously with addr 5 → pipe_stall=1 on the 5th cycle only. That cycle grants the MDU head, and the pipeline write of 5 is granted next cycle.
6. $0 handling: wb_addr=0 with queued head addr 7 → head written that cycle. md_addr=0 accepted, no enqueue, pending_mask unchanged.
